dish_wash_ctrl_param: RTL and testbench

Parametrised successor to the automatic_washing_machine controller for the dishwasher (Rua_Bat) FSM.
- Wash and dry durations come from internal cycle timers; the wash_timeout and drying_timeout inputs are removed.
- A configurable number of rinse passes follows the soap wash.
- Fill and drain have watchdog timeouts, a door-open interlock and an abort input, all routed to a latched FAULT state.
- Sits between the front-panel/sensor inputs and the valve/motor actuator drivers.

---
 rtl/dish_wash_pkg.sv | 40 ++++
 rtl/dish_wash_ctrl_param_phase_timer.sv | 28 ++
 rtl/dish_wash_ctrl_param.sv | 159 +++++++++++++++
 tb/tb_dish_wash_ctrl_param.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dish_wash_pkg.sv
// rtl/dish_wash_pkg.sv - shared state and fault-code encodings for the dishwasher controller
// Purpose : state encoding (12 states, 4 bits) and fault_code constants used by
//           dish_wash_ctrl_param and its testbench.
// Ports   : none (package).
package dish_wash_pkg;

  localparam logic [3:0] ST_IDLE        = 4'd0;
  localparam logic [3:0] ST_LOCK        = 4'd1;
  localparam logic [3:0] ST_FILL_SOAP   = 4'd2;
  localparam logic [3:0] ST_ADD_SOAP    = 4'd3;
  localparam logic [3:0] ST_SOAP_WASH   = 4'd4;
  localparam logic [3:0] ST_DRAIN_SOAP  = 4'd5;
  localparam logic [3:0] ST_FILL_RINSE  = 4'd6;
  localparam logic [3:0] ST_RINSE       = 4'd7;
  localparam logic [3:0] ST_DRAIN_RINSE = 4'd8;
  localparam logic [3:0] ST_DRY         = 4'd9;
  localparam logic [3:0] ST_DONE        = 4'd10;
  localparam logic [3:0] ST_FAULT       = 4'd11;

  typedef enum logic [3:0] {
    S_IDLE        = ST_IDLE,
    S_LOCK        = ST_LOCK,
    S_FILL_SOAP   = ST_FILL_SOAP,
    S_ADD_SOAP    = ST_ADD_SOAP,
    S_SOAP_WASH   = ST_SOAP_WASH,
    S_DRAIN_SOAP  = ST_DRAIN_SOAP,
    S_FILL_RINSE  = ST_FILL_RINSE,
    S_RINSE       = ST_RINSE,
    S_DRAIN_RINSE = ST_DRAIN_RINSE,
    S_DRY         = ST_DRY,
    S_DONE        = ST_DONE,
    S_FAULT       = ST_FAULT
  } state_e;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_FILL  = 2'd1;
  localparam logic [1:0] FC_DRAIN = 2'd2;
  localparam logic [1:0] FC_DOOR  = 2'd3;

endpackage

// File: rtl/dish_wash_ctrl_param_phase_timer.sv
// rtl/dish_wash_ctrl_param_phase_timer.sv - per-phase cycle counter with terminal compare
// Purpose : counts clocks spent in the current FSM phase.
// Ports   : clk, reset (sync, active-high), clr_i (zero the count), en_i (count up),
//           cmp_i (terminal value), hit_o (count == cmp_i).
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cmp_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit_o = (cnt_q == cmp_i);

endmodule

// File: rtl/dish_wash_ctrl_param.sv
// rtl/dish_wash_ctrl_param.sv - parametrised dishwasher sequencing FSM
// Purpose : lock -> fill -> soap -> soap wash -> drain -> N x (fill/rinse/drain) -> dry -> done,
//           with fill/drain watchdogs, door/abort interlock and a latched FAULT state.
// Ports   : clk, reset (sync, active-high); sensors door_close, start, filled, soap_added,
//           drained, abort; actuators door_lock, fill_valve_on, drain_valve_on, motor_on;
//           status soap_wash, water_wash, done, fault, fault_code[1:0], rinse_idx[3:0].
module dish_wash_ctrl_param
  import dish_wash_pkg::*;
#(
  parameter int WASH_CYCLES   = 16,
  parameter int RINSE_COUNT   = 2,
  parameter int DRY_CYCLES    = 32,
  parameter int FILL_TIMEOUT  = 64,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       door_close,
  input  logic       start,
  input  logic       filled,
  input  logic       soap_added,
  input  logic       drained,
  input  logic       abort,
  output logic       door_lock,
  output logic       fill_valve_on,
  output logic       drain_valve_on,
  output logic       motor_on,
  output logic       soap_wash,
  output logic       water_wash,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [3:0] rinse_idx
);

  state_e           state_q, state_d;
  logic [1:0]       fc_q, fc_d;
  logic [3:0]       ri_q, ri_d;
  logic             drain_done_q, drain_done_d;  // FAULT-state tank has emptied
  logic [7:0]       outs_q;
  logic [CNT_W-1:0] cmp;
  logic             timed, hit, in_fill, in_drain, in_run, fill_to, drain_to;

  // {door_lock, fill, drain, motor, soap_wash, water_wash, done, fault}
  function automatic logic [7:0] decode(input state_e s, input logic dd);
    logic [7:0] o;
    o = 8'b0;
    case (s)
      S_LOCK, S_ADD_SOAP:            o = 8'b1000_0000;
      S_FILL_SOAP, S_FILL_RINSE:     o = 8'b1100_0000;
      S_SOAP_WASH:                   o = 8'b1001_1000;
      S_DRAIN_SOAP, S_DRAIN_RINSE:   o = 8'b1010_0000;
      S_RINSE:                       o = 8'b1001_0100;
      S_DRY:                         o = 8'b1001_0000;
      S_DONE:                        o = 8'b0000_0010;
      S_FAULT:                       o = dd ? 8'b0000_0001 : 8'b1010_0001;
      default:                       o = 8'b0;
    endcase
    return o;
  endfunction

  assign in_fill  = (state_q == S_FILL_SOAP)  || (state_q == S_FILL_RINSE);
  assign in_drain = (state_q == S_DRAIN_SOAP) || (state_q == S_DRAIN_RINSE);
  assign in_run   = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAULT);
  // Sensor wins over a watchdog expiring in the same cycle.
  assign fill_to  = in_fill  && hit && !filled;
  assign drain_to = in_drain && hit && !drained;

  // One shared timer; the terminal value depends on which phase is active.
  always_comb begin
    cmp   = '0;
    timed = 1'b1;
    case (state_q)
      S_SOAP_WASH, S_RINSE:        cmp = CNT_W'(WASH_CYCLES - 1);
      S_DRY:                       cmp = CNT_W'(DRY_CYCLES - 1);
      S_FILL_SOAP, S_FILL_RINSE:   cmp = CNT_W'(FILL_TIMEOUT - 1);
      S_DRAIN_SOAP, S_DRAIN_RINSE: cmp = CNT_W'(DRAIN_TIMEOUT - 1);
      default:                     timed = 1'b0;
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_d != state_q),
    .en_i  (timed),
    .cmp_i (cmp),
    .hit_o (hit)
  );

  always_comb begin
    state_d      = state_q;
    fc_d         = fc_q;
    ri_d         = ri_q;
    drain_done_d = drain_done_q;
    case (state_q)
      S_IDLE:        if (start && door_close) state_d = S_LOCK;
      S_LOCK:        state_d = S_FILL_SOAP;
      S_FILL_SOAP:   if (filled) state_d = S_ADD_SOAP;
      S_ADD_SOAP:    if (soap_added) state_d = S_SOAP_WASH;
      S_SOAP_WASH:   if (hit) state_d = S_DRAIN_SOAP;
      S_DRAIN_SOAP:  if (drained) state_d = S_FILL_RINSE;
      S_FILL_RINSE:  if (filled) state_d = S_RINSE;
      S_RINSE:       if (hit) state_d = S_DRAIN_RINSE;
      S_DRAIN_RINSE: begin
        if (drained) begin
          if (ri_q == 4'(RINSE_COUNT - 1)) begin
            state_d = S_DRY;
          end else begin
            ri_d    = ri_q + 4'd1;
            state_d = S_FILL_RINSE;
          end
        end
      end
      S_DRY:         if (hit) state_d = S_DONE;
      S_DONE: begin
        if (!door_close) begin
          state_d = S_IDLE;
          ri_d    = 4'd0;
        end
      end
      S_FAULT:       if (drained) drain_done_d = 1'b1;
      default:       state_d = S_IDLE;
    endcase

    // Interlock overrides any normal transition; rinse_idx freezes at the faulting pass.
    if (in_run && (abort || !door_close || fill_to || drain_to)) begin
      state_d      = S_FAULT;
      ri_d         = ri_q;
      drain_done_d = 1'b0;
      if (abort || !door_close) fc_d = FC_DOOR;
      else if (fill_to)         fc_d = FC_FILL;
      else                      fc_d = FC_DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fc_q         <= FC_NONE;
      ri_q         <= 4'd0;
      drain_done_q <= 1'b0;
      outs_q       <= 8'b0;
    end else begin
      state_q      <= state_d;
      fc_q         <= fc_d;
      ri_q         <= ri_d;
      drain_done_q <= drain_done_d;
      outs_q       <= decode(state_d, drain_done_d);
    end
  end

  assign {door_lock, fill_valve_on, drain_valve_on, motor_on,
          soap_wash, water_wash, done, fault} = outs_q;
  assign fault_code = fc_q;
  assign rinse_idx  = ri_q;

endmodule

// File: tb/tb_dish_wash_ctrl_param.sv
// tb/tb_dish_wash_ctrl_param.sv - directed self-checking bench for dish_wash_ctrl_param
module tb_dish_wash_ctrl_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic door_close = 1'b1;
  logic start = 1'b0;
  logic filled = 1'b0;
  logic soap_added = 1'b0;
  logic drained = 1'b0;
  logic abort = 1'b0;
  logic door_lock, fill_valve_on, drain_valve_on, motor_on;
  logic soap_wash, water_wash, done, fault;
  logic [1:0] fault_code;
  logic [3:0] rinse_idx;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dish_wash_ctrl_param #(
    .WASH_CYCLES(4), .RINSE_COUNT(2), .DRY_CYCLES(3),
    .FILL_TIMEOUT(8), .DRAIN_TIMEOUT(8), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .door_close(door_close), .start(start),
    .filled(filled), .soap_added(soap_added), .drained(drained), .abort(abort),
    .door_lock(door_lock), .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
    .motor_on(motor_on), .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
    .fault(fault), .fault_code(fault_code), .rinse_idx(rinse_idx)
  );

  // Output bundle order: door_lock fill drain motor soap water done fault
  localparam logic [7:0] O_IDLE  = 8'b0000_0000;
  localparam logic [7:0] O_LOCK  = 8'b1000_0000;
  localparam logic [7:0] O_FILL  = 8'b1100_0000;
  localparam logic [7:0] O_SOAP  = 8'b1001_1000;
  localparam logic [7:0] O_DRAIN = 8'b1010_0000;
  localparam logic [7:0] O_RINSE = 8'b1001_0100;
  localparam logic [7:0] O_DRY   = 8'b1001_0000;
  localparam logic [7:0] O_DONE  = 8'b0000_0010;
  localparam logic [7:0] O_FDRN  = 8'b1010_0001;
  localparam logic [7:0] O_FEND  = 8'b0000_0001;

  logic [7:0] obs;
  assign obs = {door_lock, fill_valve_on, drain_valve_on, motor_on,
                soap_wash, water_wash, done, fault};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] eo, input logic [1:0] efc,
                     input logic [3:0] eri);
    vectors++;
    assert ({obs, fault_code, rinse_idx} === {eo, efc, eri}) else begin
      miscompares++;
      $error("FAIL %s: observed out=%b fc=%0d ri=%0d, expected out=%b fc=%0d ri=%0d",
             tag, obs, fault_code, rinse_idx, eo, efc, eri);
    end
  endtask

  task automatic hold(input int n, input string tag, input logic [7:0] eo,
                      input logic [1:0] efc, input logic [3:0] eri);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, eo, efc, eri);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; door_close = 1'b1; start = 1'b0; filled = 1'b0;
    soap_added = 1'b0; drained = 1'b0; abort = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_filled();  filled = 1'b1;     tick(); filled = 1'b0;     endtask
  task automatic pulse_drained(); drained = 1'b1;    tick(); drained = 1'b0;    endtask
  task automatic pulse_soap();    soap_added = 1'b1; tick(); soap_added = 1'b0; endtask

  // Ends one clock into DRAIN_SOAP (timer = 0).
  task automatic quick_to_drain_soap();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    pulse_filled();
    pulse_soap();
    repeat (4) tick();
  endtask

  // From a DRAIN state: drain, fill, rinse 4 clocks; ends in DRAIN_RINSE.
  task automatic rinse_pass();
    pulse_drained();
    pulse_filled();
    repeat (4) tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("reset", O_IDLE, 2'd0, 4'd0);

    // Fill watchdog: valve open exactly 8 clocks then fault code 1
    start = 1'b1; tick(); start = 1'b0;
    chk("wd_lock", O_LOCK, 2'd0, 4'd0);
    tick();
    chk("wd_fill0", O_FILL, 2'd0, 4'd0);
    hold(7, "wd_fill", O_FILL, 2'd0, 4'd0);
    tick();
    chk("wd_fault", O_FDRN, 2'd1, 4'd0);
    pulse_drained();
    chk("wd_drained", O_FEND, 2'd1, 4'd0);
    hold(2, "wd_stay", O_FEND, 2'd1, 4'd0);

    // Door opened during rinse pass 1
    quick_to_drain_soap();
    rinse_pass();
    pulse_drained();
    pulse_filled();
    chk("door_rinse1", O_RINSE, 2'd0, 4'd1);
    tick();
    door_close = 1'b0;
    tick();
    chk("door_fault", O_FDRN, 2'd3, 4'd1);
    door_close = 1'b1; start = 1'b1;
    tick();
    chk("door_start_ign", O_FDRN, 2'd3, 4'd1);
    pulse_drained();
    chk("door_drained", O_FEND, 2'd3, 4'd1);
    hold(2, "door_stay", O_FEND, 2'd3, 4'd1);
    start = 1'b0;

    // drained coinciding with drain timeout: sensor wins
    quick_to_drain_soap();
    chk("col_drain0", O_DRAIN, 2'd0, 4'd0);
    hold(7, "col_drain", O_DRAIN, 2'd0, 4'd0);
    pulse_drained();
    chk("col_to_fill", O_FILL, 2'd0, 4'd0);
    pulse_filled();
    repeat (4) tick();
    chk("to_drain_r", O_DRAIN, 2'd0, 4'd0);
    hold(7, "dto_drain", O_DRAIN, 2'd0, 4'd0);
    tick();
    chk("dto_fault", O_FDRN, 2'd2, 4'd0);

    // Abort in SOAP_WASH
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    pulse_filled();
    pulse_soap();
    chk("ab_soap", O_SOAP, 2'd0, 4'd0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_fault", O_FDRN, 2'd3, 4'd0);

    // Reset mid-DRY
    quick_to_drain_soap();
    rinse_pass();
    rinse_pass();
    pulse_drained();
    chk("rst_dry", O_DRY, 2'd0, 4'd1);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid_dry", O_IDLE, 2'd0, 4'd0);

    // Nominal run from IDLE; sensors answer 2 clocks after each request
    start = 1'b1; tick(); start = 1'b0;
    chk("nom_lock", O_LOCK, 2'd0, 4'd0);
    hold(2, "nom_fill", O_FILL, 2'd0, 4'd0);
    pulse_filled();
    chk("nom_add", O_LOCK, 2'd0, 4'd0);
    tick();
    chk("nom_add2", O_LOCK, 2'd0, 4'd0);
    pulse_soap();
    chk("nom_soap", O_SOAP, 2'd0, 4'd0);
    hold(3, "nom_soap", O_SOAP, 2'd0, 4'd0);
    hold(2, "nom_dsoap", O_DRAIN, 2'd0, 4'd0);
    for (int p = 0; p < 2; p++) begin
      pulse_drained();
      chk("nom_fillr", O_FILL, 2'd0, 4'(p));
      tick();
      chk("nom_fillr2", O_FILL, 2'd0, 4'(p));
      pulse_filled();
      chk("nom_rinse", O_RINSE, 2'd0, 4'(p));
      hold(3, "nom_rinse", O_RINSE, 2'd0, 4'(p));
      hold(2, "nom_drainr", O_DRAIN, 2'd0, 4'(p));
    end
    pulse_drained();
    chk("nom_dry", O_DRY, 2'd0, 4'd1);
    hold(2, "nom_dry", O_DRY, 2'd0, 4'd1);
    tick();
    chk("nom_done", O_DONE, 2'd0, 4'd1);
    abort = 1'b1; start = 1'b1;
    tick();
    chk("done_abort_ign", O_DONE, 2'd0, 4'd1);
    abort = 1'b0; door_close = 1'b0;
    tick();
    chk("nom_idle", O_IDLE, 2'd0, 4'd0);
    tick();
    chk("nom_idle_open", O_IDLE, 2'd0, 4'd0);
    start = 1'b0; door_close = 1'b1;
    tick();
    chk("nom_idle_final", O_IDLE, 2'd0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
